// File: rtl/vmem_pkg.sv
// ---------------------------------------------------------------------------
// vmem_pkg
// Shared constants and types for the vector data-memory sequencer.
//
// Contents:
//   LANES, DW, AW, ELEM_BYTES : vector geometry and address-step scale
//   IDX_W, LAST_LANE          : lane counter width and its terminal value
//   elem_t / vec_t / addr_t   : one element, a whole lane-indexed vector,
//                               and a byte address
//   vseq_state_t              : sequencer FSM states
// ---------------------------------------------------------------------------
package vmem_pkg;

    localparam int LANES      = 16;
    localparam int DW         = 16;
    localparam int AW         = 16;
    localparam int ELEM_BYTES = 2;

    // Lane counter width; LANES is a power of two here, but the counter is
    // wrapped explicitly at LAST_LANE so other lane counts still work.
    localparam int IDX_W = $clog2(LANES);

    typedef logic [DW-1:0]     elem_t;
    typedef elem_t [LANES-1:0] vec_t;
    typedef logic [AW-1:0]     addr_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam idx_t LAST_LANE = idx_t'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } vseq_state_t;

endpackage

// File: rtl/vmem_addr_gen.sv
// ---------------------------------------------------------------------------
// vmem_addr_gen
// Strided byte-address generator for the vector memory sequencer. All of the
// wrap-around address arithmetic lives here so the sequencer never has to
// reason about overflow.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   load base and stride (takes priority over advance)
//   advance  in   step the address by one lane
//   base     in   byte address of lane 0
//   stride   in   signed element stride (two's complement)
//   addr     out  byte address of the current lane
// ---------------------------------------------------------------------------
module vmem_addr_gen
    import vmem_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  logic  advance,
    input  addr_t base,
    input  addr_t stride,
    output addr_t addr
);

    addr_t addr_q;
    addr_t step_q;

    // Byte step for one lane. The stride is already AW bits wide, so the
    // low AW bits of the product are identical to those of the
    // sign-extended product; truncating to AW gives the mod-2^AW step.
    function automatic addr_t lane_step(input addr_t s);
        return s * addr_t'(ELEM_BYTES);
    endfunction

    // The scaled step is computed once at start and held in a register, so
    // the per-lane path is a single AW-bit adder that wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            step_q <= '0;
        end else if (start) begin
            addr_q <= base;
            step_q <= lane_step(stride);
        end else if (advance) begin
            addr_q <= addr_q + step_q;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/vector_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vector_mem_sequencer
// Takes one vector load or store from the CPU pipeline and serialises it into
// one 16-bit element access per cycle on the data-memory port, stepping the
// address by a programmable element stride. Loads are gathered into a vector
// and returned on a valid/ready response handshake; stores have no response.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request offered
//   req_ready   out  request can be accepted (IDLE and out of reset)
//   req_we      in   1 = store, 0 = load
//   req_base    in   byte address of lane 0
//   req_stride  in   signed element stride
//   req_wd      in   lane-indexed store data
//   rsp_valid   out  gathered load data available
//   rsp_ready   in   consumer takes the response
//   rsp_rd      out  gathered load data, lane-indexed
//   busy        out  sequencer not in IDLE
//   mem_we      out  memory write enable
//   mem_a       out  memory byte address
//   mem_wd      out  memory write data
//   mem_rd      in   memory read data (combinational read of mem_a)
// ---------------------------------------------------------------------------
module vector_mem_sequencer
    import vmem_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_we,
    input  addr_t req_base,
    input  addr_t req_stride,
    input  vec_t  req_wd,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output vec_t  rsp_rd,
    output logic  busy,
    output logic  mem_we,
    output addr_t mem_a,
    output elem_t mem_wd,
    input  elem_t mem_rd
);

    vseq_state_t state;
    vseq_state_t next_state;

    idx_t  idx;
    vec_t  wd_q;
    vec_t  gather_buf;
    addr_t cur_addr;
    logic  accept;
    logic  advance;
    logic  last_lane;

    assign last_lane = (idx == LAST_LANE);
    assign accept    = req_valid && req_ready;

    // Address generator owns base/stride and the wrapping lane address.
    vmem_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .advance (advance),
        .base    (req_base),
        .stride  (req_stride),
        .addr    (cur_addr)
    );

    // State register. Because reset is asynchronous, pulling rst_n low in
    // the middle of a store drops the FSM to IDLE at once, which in turn
    // drops mem_we combinationally within the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. The memory port is forced quiet
    // outside STORE/LOAD so the memory never sees a stale address.
    // req_ready also looks at rst_n so nothing is offered during reset.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        mem_we     = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        advance    = 1'b0;

        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    next_state = req_we ? STORE : LOAD;
                end
            end
            STORE: begin
                mem_we  = 1'b1;
                mem_a   = cur_addr;
                mem_wd  = wd_q[idx];
                advance = 1'b1;
                if (last_lane) begin
                    next_state = IDLE;
                end
            end
            LOAD: begin
                mem_a   = cur_addr;
                advance = 1'b1;
                if (last_lane) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Lane counter. Cleared on accept and stepped once per element access;
    // it is wrapped explicitly so it is back at zero after the last lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (advance) begin
            idx <= last_lane ? '0 : idx + idx_t'(1);
        end
    end

    // Store-data register. The whole vector is captured at accept so the
    // pipeline is free to change req_wd while the store is still draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (accept) begin
            wd_q <= req_wd;
        end
    end

    // Gather buffer. Each LOAD cycle writes the combinational read data for
    // the current lane. Reset clears it so a lost response leaves nothing
    // behind on rsp_rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gather_buf <= '0;
        end else if (state == LOAD) begin
            gather_buf[idx] <= mem_rd;
        end
    end

    assign rsp_rd = gather_buf;

endmodule
